// File: rtl/poly_operand_streamer.sv
// Streams one selected polynomial (small or full-width) as LANES widened coefficients per beat.
// Optional build macro KYBER_STREAM_MODQ_EN: negative small coefficients are emitted as Q+c.

module poly_lane_widen #(
  parameter int SPOLY_WIDTH = 3,
  parameter int R_WIDTH     = 12,
  parameter int ARITH_WIDTH = 16,
  parameter int NEG_BASE    = 0
) (
  input  logic [SPOLY_WIDTH-1:0] small_c,
  input  logic [R_WIDTH-1:0]     full_c,
  input  logic                   use_full,
  output logic [ARITH_WIDTH-1:0] coef
);
  logic [ARITH_WIDTH-1:0] small_sext;
  logic [ARITH_WIDTH-1:0] small_w;

  assign small_sext = {{(ARITH_WIDTH-SPOLY_WIDTH){small_c[SPOLY_WIDTH-1]}}, small_c};
  // NEG_BASE + c: with base 2^ARITH_WIDTH this is plain sign extension, with base Q it is Q+c
  assign small_w    = small_c[SPOLY_WIDTH-1] ? (ARITH_WIDTH'(NEG_BASE) + small_sext) : small_sext;
  assign coef       = use_full ? {{(ARITH_WIDTH-R_WIDTH){1'b0}}, full_c} : small_w;
endmodule

module poly_operand_streamer #(
  parameter int N           = 256,
  parameter int SPOLY_WIDTH = 3,
  parameter int R_WIDTH     = 12,
  parameter int ARITH_WIDTH = 16,
  parameter int NUM_SMALL   = 4,
  parameter int LANES       = 8,
  parameter int Q           = 3329,
  localparam int SEL_W      = $clog2(NUM_SMALL+1),
  localparam int BEATS      = N / LANES,
  localparam int IDX_W      = $clog2(BEATS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [SEL_W-1:0]                 sel,
  input  logic [NUM_SMALL*N*SPOLY_WIDTH-1:0] in_small,
  input  logic [N*R_WIDTH-1:0]             in_full,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*ARITH_WIDTH-1:0]     out_data,
  output logic [IDX_W-1:0]                 out_idx,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
`ifdef KYBER_STREAM_MODQ_EN
  localparam bit MODQ_EN = 1'b1;
`else
  localparam bit MODQ_EN = 1'b0;
`endif
  localparam int NEG_BASE = MODQ_EN ? Q : (2 ** ARITH_WIDTH);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                               state_q, state_d;
  logic [SEL_W-1:0]                     sel_q, sel_d;
  logic [IDX_W-1:0]                     out_idx_q, out_idx_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 out_last_q, out_last_d;
  logic                                 done_q, done_d;
  logic                                 err_q, err_d;
  logic [LANES-1:0][ARITH_WIDTH-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0][ARITH_WIDTH-1:0]    beat_data;

  logic [SEL_W-1:0] fetch_sel;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] next_idx;
  logic             fetch_full;
  logic [31:0]      small_p;

  // In IDLE the beat being loaded is beat 0 of the requested poly; in STREAM it is the next beat
  assign next_idx   = out_idx_q + IDX_W'(1);
  assign fetch_sel  = (state_q == IDLE) ? sel : sel_q;
  assign fetch_idx  = (state_q == IDLE) ? '0 : next_idx;
  assign fetch_full = (32'(fetch_sel) == NUM_SMALL);
  assign small_p    = (32'(fetch_sel) < NUM_SMALL) ? 32'(fetch_sel) : 32'd0;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [31:0] k;
    assign k = 32'(fetch_idx) * LANES + j;
    poly_lane_widen #(
      .SPOLY_WIDTH(SPOLY_WIDTH), .R_WIDTH(R_WIDTH),
      .ARITH_WIDTH(ARITH_WIDTH), .NEG_BASE(NEG_BASE)
    ) u_widen (
      .small_c (in_small[(small_p*N + k)*SPOLY_WIDTH +: SPOLY_WIDTH]),
      .full_c  (in_full[k*R_WIDTH +: R_WIDTH]),
      .use_full(fetch_full),
      .coef    (beat_data[j])
    );
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (32'(sel) <= NUM_SMALL) begin
            state_d     = STREAM;
            sel_d       = sel;
            out_idx_d   = '0;
            out_valid_d = 1'b1;
            out_last_d  = (BEATS == 1);
            out_data_d  = beat_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_idx_d   = '0;
            done_d      = 1'b1;
          end else begin
            out_idx_d  = next_idx;
            out_last_d = (next_idx == IDX_W'(BEATS-1));
            out_data_d = beat_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == STREAM);
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_poly_operand_streamer.sv
// Randomized bench for poly_operand_streamer against an array-based coefficient model.
module tb_poly_operand_streamer;
  localparam int N = 256, SPW = 3, RW = 12, AW = 16, NS = 4, L = 8, Q = 3329;
  localparam int SELW = 3, BEATS = 32, IDXW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n, start, out_ready;
  logic [SELW-1:0]      sel;
  logic [NS*N*SPW-1:0]  in_small;
  logic [N*RW-1:0]      in_full;
  logic                 out_valid, out_last, busy, done, err;
  logic [L*AW-1:0]      out_data;
  logic [IDXW-1:0]      out_idx;

  int sm[NS][N];
  int fm[N];
  int errors = 0, checks = 0;

  logic [L*AW-1:0] got_data[$];
  int              got_idx[$];
  logic            got_last[$];
  int              stall_viol;
  logic            done_after, valid_after;

  always #5 clk = ~clk;

  poly_operand_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .in_small(in_small), .in_full(in_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  task automatic pack_inputs();
    for (int p = 0; p < NS; p++)
      for (int k = 0; k < N; k++) in_small[(p*N+k)*SPW +: SPW] = SPW'(sm[p][k]);
    for (int k = 0; k < N; k++) in_full[k*RW +: RW] = RW'(fm[k]);
  endtask

  task automatic rand_small(input int p);
    for (int k = 0; k < N; k++) sm[p][k] = int'($urandom_range(0, 7)) - 4;
  endtask

  task automatic rand_full();
    for (int k = 0; k < N; k++) fm[k] = int'($urandom_range(0, 4095));
  endtask

  // Reference: coefficient value per the widening rules, computed as plain integers
  function automatic logic [L*AW-1:0] exp_beat(input int s, input int b);
    logic [L*AW-1:0] v;
    int c;
    v = '0;
    for (int j = 0; j < L; j++) begin
      c = (s == NS) ? fm[b*L+j] : sm[s][b*L+j];
`ifdef KYBER_STREAM_MODQ_EN
      if (c < 0) c = Q + c;
`else
      if (c < 0) c = 65536 + c;
`endif
      v[j*AW +: AW] = AW'(c);
    end
    return v;
  endfunction

  task automatic do_start(input logic [SELW-1:0] s);
    start = 1'b1; sel = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records every handshaken beat; mode 0 = always ready, 1 = toggling, 2 = random
  task automatic collect(input int mode, input int budget);
    logic ready, hold, fin, pl;
    logic [L*AW-1:0] pd;
    logic [IDXW-1:0] pi;
    got_data.delete(); got_idx.delete(); got_last.delete();
    stall_viol = 0; done_after = 1'b0; valid_after = 1'b1; fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~c[0] : 1'($urandom_range(0, 1));
      out_ready = ready;
      hold = out_valid && !ready;
      pd = out_data; pi = out_idx; pl = out_last;
      if (out_valid && ready) begin
        got_data.push_back(out_data); got_idx.push_back(int'(out_idx)); got_last.push_back(out_last);
        fin = out_last;
      end
      @(posedge clk); #1;
      if (hold && (out_data !== pd || out_idx !== pi || out_last !== pl)) stall_viol++;
      if (fin) begin done_after = done; valid_after = out_valid; end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, busy, done, err, out_last} !== 5'b0 || out_idx !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_hold: valid=%b busy=%b done=%b err=%b idx=%0d data=%h, want all 0",
                         out_valid, busy, done, err, out_idx, out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, done, err, out_last} !== 5'b0) begin
      errors++; $display("FAIL reset_release: valid=%b busy=%b done=%b err=%b, want 0", out_valid, busy, done, err);
    end
  endtask

  task automatic test_small_seq();
    logic [L*AW-1:0] d;
    logic [AW-1:0] e;
    for (int k = 0; k < N; k++) sm[0][k] = (k % 8) - 4;
    pack_inputs();
    do_start(3'd0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL small_latency: valid=%b idx=%0d busy=%b, want 1 0 1", out_valid, out_idx, busy);
    end
    collect(0, 64);
    checks++;
    if (got_data.size() != BEATS) begin
      errors++; $display("FAIL small_count: beats=%0d, want %0d", got_data.size(), BEATS);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_idx[i] != i || got_last[i] !== (i == BEATS-1) || got_data[i] !== exp_beat(0, i)) begin
        errors++; $display("FAIL small_beat%0d: idx=%0d last=%b data=%h, want idx=%0d data=%h",
                           i, got_idx[i], got_last[i], got_data[i], i, exp_beat(0, i));
      end
    end
    if (got_data.size() > 0) begin
      d = got_data[0];
      for (int j = 0; j < L; j++) begin
`ifdef KYBER_STREAM_MODQ_EN
        e = (j < 4) ? AW'(Q - 4 + j) : AW'(j - 4);
`else
        e = 16'hFFFC + AW'(j);
`endif
        checks++;
        if (d[j*AW +: AW] !== e) begin
          errors++; $display("FAIL small_lane%0d: got %h, want %h", j, d[j*AW +: AW], e);
        end
      end
    end
    checks++;
    if (done_after !== 1'b1 || valid_after !== 1'b0) begin
      errors++; $display("FAIL small_done: done=%b valid=%b, want 1 0", done_after, valid_after);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_full();
    logic [L*AW-1:0] d;
    for (int k = 0; k < N; k++) fm[k] = k * 13;
    pack_inputs();
    do_start(3'd4);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== '0) begin
      errors++; $display("FAIL full_latency: valid=%b idx=%0d, want 1 0", out_valid, out_idx);
    end
    collect(2, 400);
    checks++;
    if (got_data.size() != BEATS) begin
      errors++; $display("FAIL full_count: beats=%0d, want %0d", got_data.size(), BEATS);
    end
    if (got_data.size() > 5) begin
      d = got_data[5];
      checks++;
      if (d[3*AW +: AW] !== 16'd559) begin
        errors++; $display("FAIL full_b5l3: got %0d, want 559", d[3*AW +: AW]);
      end
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_idx[i] != i || got_data[i] !== exp_beat(NS, i)) begin
        errors++; $display("FAIL full_beat%0d: idx=%0d data=%h, want %h", i, got_idx[i], got_data[i], exp_beat(NS, i));
      end
    end
    checks++;
    if (stall_viol != 0 || done_after !== 1'b1) begin
      errors++; $display("FAIL full_end: stall_changes=%0d done=%b, want 0 1", stall_viol, done_after);
    end
  endtask

  task automatic test_stall();
    logic ok;
    rand_small(2); pack_inputs();
    do_start(3'd2);
    collect(1, 200);
    ok = (got_data.size() == BEATS);
    for (int i = 0; i < got_data.size(); i++)
      if (got_idx[i] != i || got_data[i] !== exp_beat(2, i) || got_last[i] !== (i == BEATS-1)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_stream: beats=%0d (want %0d) or a beat differs from model", got_data.size(), BEATS);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL stall_stable: %0d output changes while stalled, want 0", stall_viol);
    end
    checks++;
    if (done_after !== 1'b1) begin
      errors++; $display("FAIL stall_done: done=%b, want 1", done_after);
    end
  endtask

  task automatic test_err();
    logic ok;
    for (int s = NS + 1; s < 8; s++) begin
      do_start(SELW'(s));
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL err_sel%0d: err=%b valid=%b busy=%b, want 1 0 0", s, err, out_valid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL err_pulse%0d: err=%b valid=%b, want 0 0", s, err, out_valid);
      end
    end
    rand_small(1); rand_small(3); pack_inputs();
    do_start(3'd1);
    start = 1'b1; sel = 3'd7;
    @(posedge clk); #1;
    sel = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || out_idx !== '0 || busy !== 1'b1 || out_data !== exp_beat(1, 0)) begin
      errors++; $display("FAIL busy_start: err=%b idx=%0d busy=%b data=%h, want 0 0 1 %h",
                         err, out_idx, busy, out_data, exp_beat(1, 0));
    end
    collect(0, 64);
    ok = (got_data.size() == BEATS);
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] !== exp_beat(1, i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL busy_stream: beats=%0d, want %0d of poly 1", got_data.size(), BEATS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    rand_small(3); pack_inputs();
    do_start(3'd3);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (out_idx !== IDXW'(10)) begin
      errors++; $display("FAIL mid_idx: idx=%0d, want 10", out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, err, out_last} !== 5'b0 || out_idx !== '0 || out_data !== '0) begin
      errors++; $display("FAIL mid_reset: valid=%b busy=%b done=%b idx=%0d data=%h, want all 0",
                         out_valid, busy, done, out_idx, out_data);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_norestart: valid=%b done=%b, want 0 0", out_valid, done);
    end
    do_start(3'd3);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== '0 || out_data !== exp_beat(3, 0)) begin
      errors++; $display("FAIL mid_restart: valid=%b idx=%0d data=%h, want 1 0 %h", out_valid, out_idx, out_data, exp_beat(3, 0));
    end
    collect(0, 64);
    checks++;
    if (got_data.size() != BEATS || done_after !== 1'b1) begin
      errors++; $display("FAIL mid_finish: beats=%0d done=%b, want %0d 1", got_data.size(), done_after, BEATS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [L*AW-1:0] d;
    logic ok;
    rand_small(1); sm[1][0] = -3; sm[1][1] = 3;
    rand_full(); pack_inputs();
    do_start(3'd1);
    collect(0, 64);
    if (got_data.size() > 0) begin
      d = got_data[0];
      checks++;
`ifdef KYBER_STREAM_MODQ_EN
      if (d[0 +: AW] !== 16'd3326 || d[AW +: AW] !== 16'd3) begin
        errors++; $display("FAIL widen_pm3: lane0=%h lane1=%h, want 0cfe 0003", d[0 +: AW], d[AW +: AW]);
      end
`else
      if (d[0 +: AW] !== 16'hFFFD || d[AW +: AW] !== 16'd3) begin
        errors++; $display("FAIL widen_pm3: lane0=%h lane1=%h, want fffd 0003", d[0 +: AW], d[AW +: AW]);
      end
`endif
    end
    checks++;
    if (done_after !== 1'b1) begin
      errors++; $display("FAIL b2b_done: done=%b, want 1", done_after);
    end
    do_start(3'd4);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== '0 || out_data !== exp_beat(NS, 0)) begin
      errors++; $display("FAIL b2b_accept: valid=%b idx=%0d data=%h, want 1 0 %h", out_valid, out_idx, out_data, exp_beat(NS, 0));
    end
    collect(2, 400);
    ok = (got_data.size() == BEATS);
    for (int i = 0; i < got_data.size(); i++)
      if (got_idx[i] != i || got_data[i] !== exp_beat(NS, i)) ok = 1'b0;
    checks++;
    if (!ok || stall_viol != 0) begin
      errors++; $display("FAIL b2b_stream: beats=%0d stall_changes=%0d, want %0d beats matching model", got_data.size(), stall_viol, BEATS);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; sel = '0;
    in_small = '0; in_full = '0;
    for (int p = 0; p < NS; p++) for (int k = 0; k < N; k++) sm[p][k] = 0;
    for (int k = 0; k < N; k++) fm[k] = 0;
    test_reset();
    test_small_seq();
    test_full();
    test_stall();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
